// File: rtl/math_pkg.sv
// Shared definitions for the sum_of_squares -> sqrt datapath: FSM state encodings
// and the 32-bit result width used by both stages.
package math_pkg;

    localparam int OUT_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GET    = 3'd1,
        SQUARE = 3'd2,
        ACC    = 3'd3,
        PUT    = 3'd4
    } state_t;

    // Window counter width; a 1-sample window still needs a 1-bit counter.
    function automatic int cnt_width(input int log2_n);
        return (log2_n > 0) ? log2_n : 1;
    endfunction

endpackage

// File: rtl/sum_of_squares_if.sv
// Sample-in / mean-square-out stb/ack bundle. master drives samples and out_ack,
// slave is the sum_of_squares block.
interface sum_of_squares_if #(
    parameter int WIDTH = 16
);
    import math_pkg::*;

    logic signed [WIDTH-1:0] in_a;
    logic                    in_stb;
    logic                    in_ack;
    logic [OUT_W-1:0]        out_z;
    logic                    out_stb;
    logic                    out_ack;

    modport master (
        output in_a, in_stb, out_ack,
        input  in_ack, out_z, out_stb
    );

    modport slave (
        input  in_a, in_stb, out_ack,
        output in_ack, out_z, out_stb
    );

endinterface

// File: rtl/square_reg.sv
// Registered signed WIDTH x WIDTH squarer; prod holds a*a (always non-negative)
// and updates only when en is high.
module square_reg #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] a,
    output logic [2*WIDTH-1:0]      prod
);

    localparam int PW = 2 * WIDTH;

    // Sign-extend then multiply modulo 2**PW: the true square is below 2**PW,
    // so the truncated unsigned product equals the signed result exactly.
    logic [PW-1:0] a_ext;
    assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod <= '0;
        end else if (en) begin
            prod <= a_ext * a_ext;
        end
    end

endmodule

// File: rtl/sum_of_squares.sv
// Mean-square of non-overlapping 2**LOG2_N sample windows, feeding the sqrt stage.
// Define SUM_OF_SQUARES_ROUND_EN for round-half-up instead of truncation.
module sum_of_squares
    import math_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LOG2_N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    sum_of_squares_if.slave  bus
);

    localparam int PW = 2 * WIDTH;
`ifdef SUM_OF_SQUARES_ROUND_EN
    localparam int AW = PW + LOG2_N + 1;
    localparam int RND_SH = (LOG2_N > 0) ? LOG2_N - 1 : 0;
    localparam logic [AW-1:0] RND = (LOG2_N > 0) ? (AW'(1) << RND_SH) : '0;
`else
    localparam int AW = PW + LOG2_N;
    localparam logic [AW-1:0] RND = '0;
`endif
    localparam int CW = cnt_width(LOG2_N);
    localparam logic [CW-1:0] LAST_CNT = CW'((64'd1 << LOG2_N) - 64'd1);

    state_t                  state, state_nxt;
    logic signed [WIDTH-1:0] a_reg, a_nxt;
    logic [AW-1:0]           acc, acc_nxt;
    logic [CW-1:0]           count, count_nxt;
    logic                    in_ack, in_ack_nxt;
    logic                    out_stb, out_stb_nxt;
    logic [OUT_W-1:0]        out_z, out_z_nxt;
    logic [PW-1:0]           prod;
    logic [AW-1:0]           sum;
    logic [AW-1:0]           mean;

    square_reg #(.WIDTH(WIDTH)) u_square (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == SQUARE),
        .a     (a_reg),
        .prod  (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_reg   <= '0;
            acc     <= '0;
            count   <= '0;
            in_ack  <= 1'b0;
            out_stb <= 1'b0;
            out_z   <= '0;
        end else begin
            state   <= state_nxt;
            a_reg   <= a_nxt;
            acc     <= acc_nxt;
            count   <= count_nxt;
            in_ack  <= in_ack_nxt;
            out_stb <= out_stb_nxt;
            out_z   <= out_z_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        a_nxt       = a_reg;
        acc_nxt     = acc;
        count_nxt   = count;
        in_ack_nxt  = in_ack;
        out_stb_nxt = out_stb;
        out_z_nxt   = out_z;
        sum         = acc + AW'(prod);
        mean        = (sum + RND) >> LOG2_N;

        case (state)
            IDLE: begin
                in_ack_nxt = 1'b1;
                state_nxt  = GET;
            end
            GET: begin
                if (bus.in_stb && in_ack) begin
                    a_nxt      = bus.in_a;
                    in_ack_nxt = 1'b0;
                    state_nxt  = SQUARE;
                end
            end
            SQUARE: begin
                state_nxt = ACC;
            end
            ACC: begin
                if (count == LAST_CNT) begin
                    // mean never exceeds 2**(2*WIDTH-2), so narrowing to OUT_W is lossless
                    out_z_nxt   = OUT_W'(mean);
                    out_stb_nxt = 1'b1;
                    acc_nxt     = '0;
                    count_nxt   = '0;
                    state_nxt   = PUT;
                end else begin
                    acc_nxt    = sum;
                    count_nxt  = count + CW'(1);
                    in_ack_nxt = 1'b1;
                    state_nxt  = GET;
                end
            end
            PUT: begin
                if (bus.out_ack) begin
                    out_stb_nxt = 1'b0;
                    in_ack_nxt  = 1'b1;
                    state_nxt   = GET;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.in_ack  = in_ack;
    assign bus.out_stb = out_stb;
    assign bus.out_z   = out_z;

endmodule

// File: tb/tb_sum_of_squares.sv
// Self-checking bench for sum_of_squares: directed windows plus random windows
// compared against a plain-arithmetic mean-square model.
module tb_sum_of_squares;

    localparam int N = 16;
`ifdef SUM_OF_SQUARES_ROUND_EN
    localparam longint RND = N / 2;
`else
    localparam longint RND = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    sum_of_squares_if #(.WIDTH(16)) bus();

    sum_of_squares #(.WIDTH(16), .LOG2_N(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rise_cyc = -1;
    int accept_cyc = -1;
    logic prev_stb = 1'b0;
    logic [31:0] got_q[$];

    always @(posedge clk) cyc++;

    // Results are captured when a handshake is pending for the next rising edge.
    always @(negedge clk) begin
        if (bus.out_stb && !prev_stb) rise_cyc = cyc;
        prev_stb = bus.out_stb;
        if (rst_n && bus.out_stb && bus.out_ack) got_q.push_back(bus.out_z);
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1);
    end

    function automatic logic [31:0] model(input longint w[$]);
        longint s = 0;
        foreach (w[i]) s += w[i] * w[i];
        return 32'((s + RND) / N);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input longint a, input bit gaps);
        bit done = 1'b0;
        int n = 0;
        while (!done && n < 200) begin
            if (bus.in_ack && !(gaps && $urandom_range(7) == 0)) begin
                bus.in_a   = 16'(a);
                bus.in_stb = 1'b1;
                @(posedge clk);
                #1;
                accept_cyc = cyc;
                bus.in_stb = 1'b0;
                bus.in_a   = 16'($urandom);
                done = 1'b1;
            end else begin
                // junk strobes while busy must be ignored
                bus.in_stb = bus.in_ack ? 1'b0 : 1'($urandom_range(1));
                bus.in_a   = 16'($urandom);
                tick(1);
                n++;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ack=%0b after %0d cycles, required 1", bus.in_ack, n);
        end
    endtask

    task automatic send_window(input longint w[$], input bit gaps);
        foreach (w[i]) send(w[i], gaps);
    endtask

    task automatic wait_result(output bit ok, output logic [31:0] z);
        ok = 1'b0;
        z  = '0;
        for (int n = 0; n < 400 && !ok; n++) begin
            if (got_q.size() > 0) begin
                z  = got_q.pop_front();
                ok = 1'b1;
            end else begin
                tick(1);
            end
        end
    endtask

    task automatic wait_stb(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            if (bus.out_stb) ok = 1'b1;
            else tick(1);
        end
    endtask

    function automatic void fill(ref longint w[$], input longint v, input int cnt);
        w.delete();
        for (int i = 0; i < cnt; i++) w.push_back(v);
    endfunction

    task automatic do_reset;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset;
        bus.in_a = '0; bus.in_stb = 1'b0; bus.out_ack = 1'b0;
        rst_n = 1'b0;
        tick(3);
        checks++;
        if (bus.in_ack !== 1'b0 || bus.out_stb !== 1'b0 || bus.out_z !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: in_ack=%0b out_stb=%0b out_z=%0d, required 0/0/0",
                     bus.in_ack, bus.out_stb, bus.out_z);
        end
        rst_n = 1'b1;
        tick(1);
        checks++;
        if (bus.in_ack !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ack: in_ack=%0b, required 1", bus.in_ack);
        end
    endtask

    task automatic test_const;
        longint w[$];
        logic [31:0] z;
        bit ok;
        bus.out_ack = 1'b1;
        got_q.delete();
        fill(w, 3, N);
        send_window(w, 1'b0);
        wait_result(ok, z);
        checks++;
        if (!ok || z !== 32'd9) begin
            errors++;
            $display("FAIL const3_z: got=%0d ok=%0b, required 9", z, ok);
        end
        // the accepting edge counts as the first of the three clocks
        checks++;
        if (rise_cyc !== accept_cyc + 2) begin
            errors++;
            $display("FAIL const3_latency: out_stb at edge %0d, required %0d", rise_cyc, accept_cyc + 2);
        end
        tick(5);
        checks++;
        if (got_q.size() != 0 || bus.out_stb !== 1'b0) begin
            errors++;
            $display("FAIL const3_single_pulse: extra=%0d out_stb=%0b, required 0/0", got_q.size(), bus.out_stb);
        end
    endtask

    task automatic test_max_neg;
        longint w[$];
        logic [31:0] z;
        bit ok;
        fill(w, -32768, N);
        send_window(w, 1'b0);
        wait_result(ok, z);
        checks++;
        if (!ok || z !== 32'd1073741824) begin
            errors++;
            $display("FAIL max_neg_z: got=%0d ok=%0b, required 1073741824", z, ok);
        end
    endtask

    task automatic test_round;
        longint w[$];
        logic [31:0] z;
        logic [31:0] exp_z;
        bit ok;
        fill(w, 0, N);
        w[0] = 3;
`ifdef SUM_OF_SQUARES_ROUND_EN
        exp_z = 32'd1;
`else
        exp_z = 32'd0;
`endif
        send_window(w, 1'b0);
        wait_result(ok, z);
        checks++;
        if (!ok || z !== exp_z) begin
            errors++;
            $display("FAIL round_z: got=%0d ok=%0b, required %0d", z, ok, exp_z);
        end
    endtask

    task automatic test_backpressure;
        longint w[$];
        logic [31:0] z, z0;
        bit ok;
        bus.out_ack = 1'b0;
        fill(w, 6, N);
        send_window(w, 1'b0);
        wait_stb(ok);
        z0 = bus.out_z;
        checks++;
        if (!ok || z0 !== 32'd36) begin
            errors++;
            $display("FAIL hold_first_z: got=%0d stb=%0b, required 36", z0, ok);
        end
        for (int i = 0; i < 10; i++) begin
            bus.in_stb = 1'b1;
            bus.in_a   = 16'($urandom);
            tick(1);
            checks++;
            if (bus.out_stb !== 1'b1 || bus.out_z !== z0 || bus.in_ack !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable[%0d]: out_stb=%0b out_z=%0d in_ack=%0b, required 1/%0d/0",
                         i, bus.out_stb, bus.out_z, bus.in_ack, z0);
            end
        end
        bus.in_stb  = 1'b0;
        bus.out_ack = 1'b1;
        fill(w, 2, N);
        send_window(w, 1'b0);
        wait_result(ok, z);
        checks++;
        if (!ok || z !== 32'd36) begin
            errors++;
            $display("FAIL hold_release_z: got=%0d ok=%0b, required 36", z, ok);
        end
        wait_result(ok, z);
        checks++;
        if (!ok || z !== 32'd4) begin
            errors++;
            $display("FAIL hold_next_window_z: got=%0d ok=%0b, required 4", z, ok);
        end
    endtask

    task automatic test_reset_mid;
        longint w[$];
        logic [31:0] z;
        bit ok;
        bus.out_ack = 1'b1;
        fill(w, 100, 7);
        send_window(w, 1'b0);
        do_reset();
        fill(w, 5, N);
        send_window(w, 1'b0);
        wait_result(ok, z);
        checks++;
        if (!ok || z !== 32'd25) begin
            errors++;
            $display("FAIL reset_mid_z: got=%0d ok=%0b, required 25", z, ok);
        end
        bus.out_ack = 1'b0;
        fill(w, 9, N);
        send_window(w, 1'b0);
        wait_stb(ok);
        rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || bus.out_stb !== 1'b0 || bus.out_z !== 32'd0) begin
            errors++;
            $display("FAIL reset_put_drop: out_stb=%0b out_z=%0d reached=%0b, required 0/0/1",
                     bus.out_stb, bus.out_z, ok);
        end
        tick(2);
        rst_n = 1'b1;
        bus.out_ack = 1'b1;
        tick(5);
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL reset_put_no_result: queued=%0d, required 0", got_q.size());
        end
        fill(w, 1, N);
        send_window(w, 1'b0);
        wait_result(ok, z);
        checks++;
        if (!ok || z !== 32'd1) begin
            errors++;
            $display("FAIL reset_put_next_z: got=%0d ok=%0b, required 1", z, ok);
        end
    endtask

    task automatic test_random;
        longint w[$];
        logic [31:0] z, exp_z;
        logic signed [15:0] r;
        bit ok;
        int hold;
        bus.out_ack = 1'b1;
        w.delete();
        for (int i = 0; i < N; i++) w.push_back((i % 2 == 0) ? 7 : -7);
        send_window(w, 1'b1);
        wait_result(ok, z);
        checks++;
        if (!ok || z !== 32'd49) begin
            errors++;
            $display("FAIL alt7_z: got=%0d ok=%0b, required 49", z, ok);
        end
        for (int wi = 0; wi < 1000; wi++) begin
            w.delete();
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(3))
                    0:       w.push_back(-32768);
                    1:       w.push_back(32767);
                    default: begin
                        r = 16'($urandom);
                        w.push_back(longint'(r));
                    end
                endcase
            end
            hold = $urandom_range(3);
            bus.out_ack = (hold == 0);
            send_window(w, 1'b1);
            if (hold > 0) begin
                tick(hold);
                bus.out_ack = 1'b1;
            end
            exp_z = model(w);
            wait_result(ok, z);
            checks++;
            if (!ok || z !== exp_z) begin
                errors++;
                $display("FAIL random_window[%0d]: got=%0d ok=%0b, required %0d", wi, z, ok, exp_z);
            end
        end
    endtask

    initial begin
        test_reset();
        test_const();
        test_max_neg();
        test_round();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
